// File: rtl/program_loader_if.sv
// Load-stream and program-RAM write bus for program_loader.
// Optional checksum output is present only when PROGRAM_LOADER_CHECKSUM_EN is defined.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  loadValid;
  logic [3:0]            loadData;
  logic                  loadLast;
  logic                  loadReady;
  logic                  memWriteEn;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [3:0]            memData;
  logic                  cpuHold;
  logic                  loadDone;
  logic [ADDR_WIDTH:0]   programLength;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [3:0]            checksumOut;
`endif

  modport master (
    output start, loadValid, loadData, loadLast,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    input  checksumOut,
`endif
    input  loadReady, memWriteEn, memAddr, memData, cpuHold, loadDone, programLength
  );

  modport slave (
    input  start, loadValid, loadData, loadLast,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    output checksumOut,
`endif
    output loadReady, memWriteEn, memAddr, memData, cpuHold, loadDone, programLength
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: streams 4-bit instruction words into program RAM from
// address 0, pads the rest with FILL_OPCODE and holds the CPU until done.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (running XOR of loaded words).
//
// state | meaning
// IDLE  | after reset, CPU held, waiting for start
// LOAD  | accepting words from the load stream
// PAD   | writing FILL_OPCODE up to the top address, then waiting for the
//       | final write strobe to appear before signalling completion
// DONE  | load complete, CPU released, start re-arms a load
module program_loader #(
  parameter int         ADDR_WIDTH  = 8,
  parameter logic [3:0] FILL_OPCODE = 4'b0111
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH:0]   MAX_LEN   = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_cnt, addr_cnt_nxt;
  logic [ADDR_WIDTH:0]   length_q, length_nxt;
  logic                  wr_en_q, wr_en_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_nxt;
  logic [3:0]            wr_data_q, wr_data_nxt;
  logic                  done_q, done_nxt;
  logic                  final_visible;

  // The top address being strobed this cycle means the image is complete.
  // Completion is signalled one cycle later so loadDone follows the final strobe.
  assign final_visible = wr_en_q && (wr_addr_q == LAST_ADDR);

  // Next-state, address counter and registered write request
  always_comb begin
    state_nxt    = state;
    addr_cnt_nxt = addr_cnt;
    length_nxt   = length_q;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr_q;
    wr_data_nxt  = wr_data_q;
    done_nxt     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt    = LOAD;
          addr_cnt_nxt = '0;
          length_nxt   = '0;
        end
      end
      LOAD: begin
        if (bus.loadValid) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = addr_cnt;
          wr_data_nxt = bus.loadData;
          if (length_q != MAX_LEN)   length_nxt   = length_q + 1'b1;
          if (addr_cnt != LAST_ADDR) addr_cnt_nxt = addr_cnt + 1'b1;
          // A word at the top address leaves nothing to pad; PAD then only
          // waits out that word's strobe.
          if (bus.loadLast || addr_cnt == LAST_ADDR) state_nxt = PAD;
        end
      end
      PAD: begin
        if (final_visible) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = addr_cnt;
          wr_data_nxt = FILL_OPCODE;
          if (addr_cnt != LAST_ADDR) addr_cnt_nxt = addr_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered RAM write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      length_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr_cnt  <= addr_cnt_nxt;
      length_q  <= length_nxt;
      wr_en_q   <= wr_en_nxt;
      wr_addr_q <= wr_addr_nxt;
      wr_data_q <= wr_data_nxt;
      done_q    <= done_nxt;
    end
  end

  assign bus.loadReady     = (state == LOAD);
  assign bus.cpuHold       = (state != DONE);
  assign bus.memWriteEn    = wr_en_q;
  assign bus.memAddr       = wr_addr_q;
  assign bus.memData       = wr_data_q;
  assign bus.loadDone      = done_q;
  assign bus.programLength = length_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [3:0] csum_q;

  // Running XOR of accepted words; pad words never reach it
  always_ff @(posedge clk) begin
    if (reset || ((state == IDLE || state == DONE) && bus.start))
      csum_q <= '0;
    else if (state == LOAD && bus.loadValid)
      csum_q <= csum_q ^ bus.loadData;
  end

  assign bus.checksumOut = csum_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader (ADDR_WIDTH=4).
// Expected RAM image, write timing and program length come from a
// word-list model; a RAM shadow records what the loader actually writes.
module tb_program_loader;
  localparam int         AW    = 4;
  localparam int         DEPTH = 16;
  localparam logic [3:0] FILL  = 4'b0111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_WIDTH(AW)) bus();
  program_loader #(.ADDR_WIDTH(AW), .FILL_OPCODE(FILL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // RAM shadow and event monitor, sampled mid-cycle
  logic [3:0] ram [DEPTH];
  int         wr_cnt [DEPTH];
  int         done_count = 0;
  int         cyc = 0;
  int         last_wr_cyc = 0;
  int         done_cyc = 0;
  logic       mon_clear = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mon_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram[i]    = 4'bx;
        wr_cnt[i] = 0;
      end
      done_count = 0;
    end else begin
      if (bus.memWriteEn) begin
        ram[bus.memAddr] = bus.memData;
        wr_cnt[bus.memAddr]++;
        last_wr_cyc = cyc;
      end
      if (bus.loadDone) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    mon_clear = 1'b1;
    tick();
    bus.start = 1'b0;
    mon_clear = 1'b0;
    check("hold_after_start", 32'(bus.cpuHold), 1);
    check("ready_in_load", 32'(bus.loadReady), 1);
    check("len_cleared", 32'(bus.programLength), 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("csum_cleared", 32'(bus.checksumOut), 0);
`endif
  endtask

  // gap: 0 = valid every cycle, 1 = valid every 3rd cycle, 2 = random
  task automatic run_load(input logic [3:0] w [DEPTH], input int n,
                          input bit use_last, input int gap);
    int         idx;
    int         budget;
    bit         v;
    bit         got_done;
    logic [3:0] exp_csum;
    logic [3:0] exp_word;
    idx      = 0;
    budget   = 0;
    exp_csum = 4'h0;
    pulse_start();
    while (idx < n && budget < 300) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (budget % 3 == 0);
        default: v = ($urandom_range(0, 2) == 0);
      endcase
      bus.loadValid = v;
      bus.loadData  = v ? w[idx] : 4'($urandom);
      bus.loadLast  = v ? (use_last && idx == n - 1) : 1'($urandom);
      bus.start     = ($urandom_range(0, 3) == 0);
      check("ready_while_loading", 32'(bus.loadReady), 1);
      tick();
      check("wr_en_follows_accept", 32'(bus.memWriteEn), 32'(v));
      if (v) begin
        check("wr_addr", 32'(bus.memAddr), 32'(idx));
        check("wr_data", 32'(bus.memData), 32'(w[idx]));
        exp_csum ^= w[idx];
        idx++;
      end
      budget++;
    end
    if (idx < n) check("load_timeout", 32'(idx), 32'(n));
    bus.start     = 1'b0;
    bus.loadLast  = 1'b0;
    bus.loadData  = 4'($urandom);
    bus.loadValid = (n == DEPTH);
    check("ready_after_final", 32'(bus.loadReady), 0);
    got_done = 1'b0;
    for (int k = 0; k < 40 && !got_done; k++) begin
      tick();
      if (bus.loadDone) got_done = 1'b1;
    end
    check("done_seen", 32'(got_done), 1);
    check("hold_low_at_done", 32'(bus.cpuHold), 0);
    check("program_length", 32'(bus.programLength), 32'(n));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("checksum", 32'(bus.checksumOut), 32'(exp_csum));
`endif
    tick();
    check("done_single_cycle", 32'(bus.loadDone), 0);
    check("hold_stays_low", 32'(bus.cpuHold), 0);
    check("ready_in_done", 32'(bus.loadReady), 0);
    bus.loadValid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_word = (i < n) ? w[i] : FILL;
      check($sformatf("ram[%0d]", i), 32'(ram[i]), 32'(exp_word));
      check($sformatf("writes[%0d]", i), 32'(wr_cnt[i]), 1);
    end
    check("done_count", 32'(done_count), 1);
    check("done_after_final_write", 32'(done_cyc), 32'(last_wr_cyc + 1));
  endtask

  logic [3:0] prog [DEPTH];
  logic [3:0] rnd  [DEPTH];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.loadValid = 1'b0;
    bus.loadData  = 4'h0;
    bus.loadLast  = 1'b0;
    reset         = 1'b1;
    repeat (3) tick();
    check("rst_hold", 32'(bus.cpuHold), 1);
    check("rst_wr_en", 32'(bus.memWriteEn), 0);
    check("rst_addr", 32'(bus.memAddr), 0);
    check("rst_data", 32'(bus.memData), 0);
    check("rst_ready", 32'(bus.loadReady), 0);
    check("rst_done", 32'(bus.loadDone), 0);
    check("rst_len", 32'(bus.programLength), 0);
    reset = 1'b0;

    // idle with a noisy load stream: nothing may be accepted or written
    for (int i = 0; i < 5; i++) begin
      bus.loadValid = 1'($urandom);
      bus.loadData  = 4'($urandom);
      tick();
      check("idle_hold", 32'(bus.cpuHold), 1);
      check("idle_wr_en", 32'(bus.memWriteEn), 0);
      check("idle_ready", 32'(bus.loadReady), 0);
      check("idle_done", 32'(bus.loadDone), 0);
    end
    bus.loadValid = 1'b0;

    for (int i = 0; i < DEPTH; i++) prog[i] = 4'h0;
    prog[0] = 4'b0000;
    prog[1] = 4'b0001;
    prog[2] = 4'b1010;
    prog[3] = 4'b0010;
    run_load(prog, 4, 1'b1, 0);
    run_load(prog, 4, 1'b1, 1);

    // full memory, loadLast never asserted
    for (int i = 0; i < DEPTH; i++) rnd[i] = 4'($urandom);
    run_load(rnd, DEPTH, 1'b0, 2);

    // random programs of random length
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < DEPTH; i++) rnd[i] = 4'($urandom);
      run_load(rnd, $urandom_range(1, DEPTH), 1'b1, 2);
    end

    // reset after two accepted words, then a reload from address 0
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      bus.loadValid = 1'b1;
      bus.loadData  = rnd[i];
      bus.loadLast  = 1'b0;
      tick();
      check("pre_reset_wr_addr", 32'(bus.memAddr), 32'(i));
    end
    reset = 1'b1;
    tick();
    check("midrst_wr_en", 32'(bus.memWriteEn), 0);
    check("midrst_hold", 32'(bus.cpuHold), 1);
    check("midrst_ready", 32'(bus.loadReady), 0);
    check("midrst_len", 32'(bus.programLength), 0);
    reset = 1'b0;
    bus.loadValid = 1'b1;
    tick();
    check("post_rst_idle_ready", 32'(bus.loadReady), 0);
    check("post_rst_idle_wr_en", 32'(bus.memWriteEn), 0);
    bus.loadValid = 1'b0;
    for (int i = 0; i < DEPTH; i++) rnd[i] = 4'($urandom);
    run_load(rnd, 7, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
